// File: rtl/nq_pkg.sv
// Shared fetch-path definitions: datapath width, default boot address, FSM encodings.
package nq_pkg;

  localparam int unsigned XLEN = 16;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: power-of-two FIFO with synchronous flush; a push into a full
// buffer succeeds when a pop happens in the same cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  // Data array carries no reset; consumers gate it with empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory request, FIFO buffer toward decode, redirect flush.
// Optional stall counter enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit
  import nq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [15:0]     stall_count
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            push, pop, flush;
  logic            fifo_full, fifo_empty;
  logic [2*XLEN-1:0] fifo_rdata;

  fetch_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .push (push),
    .wdata({imem_data, pc_q}),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign inst_valid = !fifo_empty;
  assign pop        = inst_valid && inst_ready;
  assign inst       = inst_valid ? fifo_rdata[2*XLEN-1:XLEN] : '0;
  assign inst_pc    = inst_valid ? fifo_rdata[XLEN-1:0] : '0;
  assign imem_addr  = pc_q;
  assign flush      = redirect;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    imem_req = 1'b0;
    push     = 1'b0;
    case (state_q)
      StIdle: begin
        if (redirect) begin
          pc_d = {redirect_pc[XLEN-1:1], 1'b0};
        end else if (!fifo_full && !rst) begin
          imem_req = 1'b1;
          state_d  = StWait;
        end
      end
      StWait: begin
        imem_req = 1'b1;
        if (redirect) begin
          // An ack in the redirect cycle is consumed and dropped here; otherwise it is still owed.
          pc_d    = {redirect_pc[XLEN-1:1], 1'b0};
          state_d = imem_ack ? StIdle : StDrop;
        end else if (imem_ack) begin
          push    = 1'b1;
          pc_d    = pc_q + XLEN'(2);
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (redirect) pc_d = {redirect_pc[XLEN-1:1], 1'b0};
        if (imem_ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (inst_valid && !inst_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, back-pressure, redirects, reset mid-request.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        a_req, a_ack, a_valid, a_ready;
  logic [15:0] a_addr, a_data, a_inst, a_pc, a_stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        b_req, b_ack, b_valid, b_ready, b_redirect;
  logic [15:0] b_addr, b_data, b_inst, b_pc, b_stall, b_redirect_pc;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_fetch;
  bit          auto_mem, a_pend, b_pend, dead_seen;
  logic [15:0] pops_pc[$], pops_inst[$], b_pcs[$], b_insts[$];

  fetch_unit u_dut_a (
    .clk(clk), .rst(rst), .imem_req(a_req), .imem_addr(a_addr), .imem_ack(a_ack),
    .imem_data(a_data), .redirect(redirect), .redirect_pc(redirect_pc), .inst(a_inst),
    .inst_pc(a_pc), .inst_valid(a_valid), .inst_ready(a_ready), .stall_count(a_stall)
  );

  fetch_unit #(.RESET_PC(16'hFFFE), .FIFO_DEPTH(2)) u_dut_b (
    .clk(clk), .rst(rst), .imem_req(b_req), .imem_addr(b_addr), .imem_ack(b_ack),
    .imem_data(b_data), .redirect(b_redirect), .redirect_pc(b_redirect_pc), .inst(b_inst),
    .inst_pc(b_pc), .inst_valid(b_valid), .inst_ready(b_ready), .stall_count(b_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] dfun(input logic [15:0] a);
    return a ^ 16'h3C5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Drive memory responses from the current cycle's request, then record what decode sees.
  task automatic settle();
    #1;
    if (auto_mem) begin
      a_ack  = a_req && a_pend;
      a_data = dfun(a_addr);
    end
    b_ack  = b_req && b_pend;
    b_data = dfun(b_addr);
    #1;
    if (a_valid && a_ready) begin
      pops_pc.push_back(a_pc);
      pops_inst.push_back(a_inst);
    end
    if (a_valid && a_inst == 16'hDEAD) dead_seen = 1'b1;
    if (b_valid) begin
      b_pcs.push_back(b_pc);
      b_insts.push_back(b_inst);
    end
    if (a_req && a_ack) n_fetch++;
  endtask

  task automatic adv();
    a_pend = a_req && !a_ack;
    b_pend = b_req && !b_ack;
    @(negedge clk);
  endtask

  task automatic clear_log();
    pops_pc.delete();
    pops_inst.delete();
    b_pcs.delete();
    b_insts.delete();
    n_fetch   = 0;
    dead_seen = 1'b0;
    a_pend    = 1'b0;
    b_pend    = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; a_ack = 1'b0; a_data = '0;
    auto_mem = 1'b1; a_ready = 1'b1;
    #1;
    chk({name, "_reset_a"}, {a_req, a_valid, a_inst, a_pc, a_stall}, '0);
    chk({name, "_reset_b"}, {b_req, b_valid, b_inst, b_pc, b_stall}, '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
  endtask

  typedef struct {
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
    logic [15:0] inst;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] exp_stall;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; a_ack = 1'b0; a_data = '0;
    a_ready = 1'b1; auto_mem = 1'b1;
    b_ready = 1'b1; b_redirect = 1'b0; b_redirect_pc = '0; b_ack = 1'b0; b_data = '0;
    clear_log();

    vecs[0] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, dfun(16'h0000)};
    vecs[3] = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0002, dfun(16'h0002)};
    vecs[5] = '{1'b1, 1'b1, 16'h0004, 1'b0, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0004, dfun(16'h0004)};

    @(negedge clk);

    // Streaming fetch with one-cycle memory; second instance boots at FFFE.
    do_reset("stream");
    for (int i = 0; i < 7; i++) begin
      a_ready = vecs[i].ready;
      settle();
      chk($sformatf("stream_c%0d", i),
          {a_req, a_addr, a_valid, a_valid ? {a_pc, a_inst} : 32'h0},
          {vecs[i].req, vecs[i].addr, vecs[i].valid,
           vecs[i].valid ? {vecs[i].pc, vecs[i].inst} : 32'h0});
      adv();
    end
    chk("wrap_pc0", b_pcs.size() > 0 ? b_pcs[0] : 'x, 16'hFFFE);
    chk("wrap_inst0", b_insts.size() > 0 ? b_insts[0] : 'x, dfun(16'hFFFE));
    chk("wrap_pc1", b_pcs.size() > 1 ? b_pcs[1] : 'x, 16'h0000);

    // Back-pressure: 12 cycles with decode stalled, valid from the third cycle on.
    do_reset("stall");
    a_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      settle();
      adv();
    end
    a_ready = 1'b1;
    settle();
`ifdef FETCH_PERF_CNT_EN
    exp_stall = 16'd10;
`else
    exp_stall = 16'd0;
`endif
    chk("stall_fetches", n_fetch, 2);
    chk("stall_req_low", a_req, 1'b0);
    chk("stall_count", a_stall, exp_stall);
    adv();
    for (int i = 0; i < 3; i++) begin
      settle();
      adv();
    end
    chk("stall_count_hold", a_stall, exp_stall);
    chk("stall_drain0", {pops_pc.size() > 0 ? pops_pc[0] : 16'hx,
                         pops_inst.size() > 0 ? pops_inst[0] : 16'hx},
        {16'h0000, dfun(16'h0000)});
    chk("stall_drain1", {pops_pc.size() > 1 ? pops_pc[1] : 16'hx,
                         pops_inst.size() > 1 ? pops_inst[1] : 16'hx},
        {16'h0002, dfun(16'h0002)});

    // Redirect while waiting; the late response must be discarded.
    do_reset("drop");
    auto_mem = 1'b0;
    a_ack = 1'b0;
    settle();
    chk("drop_first_req", {a_req, a_addr}, {1'b1, 16'h0000});
    adv();
    redirect = 1'b1; redirect_pc = 16'h0040;
    settle();
    adv();
    redirect = 1'b0;
    settle();
    chk("drop_quiet", {a_req, a_valid}, 2'b00);
    adv();
    settle();
    adv();
    a_ack = 1'b1; a_data = 16'hDEAD;
    settle();
    chk("drop_late_ack_req", a_req, 1'b0);
    adv();
    a_ack = 1'b0; auto_mem = 1'b1;
    settle();
    chk("drop_refetch", {a_req, a_addr, a_valid}, {1'b1, 16'h0040, 1'b0});
    adv();
    for (int i = 0; i < 4 && pops_pc.size() == 0; i++) begin
      settle();
      adv();
    end
    chk("drop_next_pc", pops_pc.size() > 0 ? pops_pc[0] : 'x, 16'h0040);
    chk("drop_no_dead", dead_seen, 1'b0);

    // Redirect coinciding with the ack; bit 0 of the target is ignored.
    do_reset("same");
    settle();
    adv();
    redirect = 1'b1; redirect_pc = 16'h0101;
    settle();
    adv();
    redirect = 1'b0;
    settle();
    chk("same_after", {a_valid, a_req, a_addr}, {1'b0, 1'b1, 16'h0100});
    adv();
    for (int i = 0; i < 3; i++) begin
      settle();
      adv();
    end
    chk("same_next", {pops_pc.size() > 0 ? pops_pc[0] : 16'hx,
                      pops_inst.size() > 0 ? pops_inst[0] : 16'hx},
        {16'h0100, dfun(16'h0100)});

    // Reset asserted mid-request with an entry buffered and a late ack.
    do_reset("rstmid");
    a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      adv();
    end
    auto_mem = 1'b0; a_ack = 1'b0;
    settle();
    adv();
    settle();
    chk("rstmid_pre", {a_req, a_valid}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rstmid_async", {a_req, a_valid, a_inst, a_pc, a_stall}, '0);
    a_ack = 1'b1; a_data = 16'hDEAD;
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    settle();
    chk("rstmid_first_req", {a_req, a_addr, a_valid}, {1'b1, 16'h0000, 1'b0});
    adv();
    a_data = dfun(16'h0000);
    settle();
    chk("rstmid_ack_ignored", a_valid, 1'b0);
    adv();
    a_ack = 1'b0; a_ready = 1'b1;
    settle();
    chk("rstmid_refetch", {a_valid, a_pc, a_inst}, {1'b1, 16'h0000, dfun(16'h0000)});
    adv();
    chk("rstmid_no_dead", dead_seen, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
